segasys1_sound_cmd_rx: RTL and testbench
========================================

// Module: segasys1_sound_cmd_rx
// PURPOSE
//  Sound-side end of the main CPU -> sound CPU command path. Captures the byte the main CPU
//  writes to I/O port 0x18 (SNDRQ strobe), queues it in a small FIFO and raises NMI on the sound
//  Z80 until the sound CPU has read it. Also generates the sound CPU's periodic IRQ, four per frame,
//  phase-locked to VBLK. Sits between the main CPU block and the sound CPU/PSG block.
// PARAMETERS
//  DEPTH       4       FIFO entries, power of two, >=2
//  NMI_W       64      NMI assert width, CLK48M cycles
//  NMI_GAP     64      min deassert gap before re-raising NMI, CLK48M cycles
//  IRQ_PERIOD  200000  CLK48M cycles between sound IRQs (48 MHz / 60 Hz / 4)
//  IRQ_W       256     IRQ assert width, CLK48M cycles (< IRQ_PERIOD)
// PORTS
//  CLK48M   in   1  single clock; all logic on rising edge
//  RESET    in   1  synchronous, active-high
//  SNDRQ    in   1  main CPU port-0x18 write strobe (level, several CLK48M cycles wide)
//  CPUDO    in   8  main CPU data bus, valid while SNDRQ high
//  VBLK     in   1  vertical blank, level
//  SNDCS    in   1  sound CPU read strobe for command latch (level)
//  SNDDO    out  8  command byte to sound CPU data selector
//  SNDNMI   out  1  NMI request to sound Z80, active-high
//  SNDIRQ   out  1  INT request to sound Z80, active-high
//  PENDING  out  1  FIFO non-empty
//  OVERRUN  out  1  sticky: a command was dropped on full FIFO
// BEHAVIOUR
//  Reset: FIFO empty, pointers/count 0, SNDDO=8'h00, SNDNMI=0, SNDIRQ=0, PENDING=0, OVERRUN=0,
//   edge detectors cleared, NMI FSM IDLE, IRQ counter 0. Reset mid-pulse drops outputs next cycle.
//  Push: on SNDRQ rising edge (registered prev value), CPUDO written at tail; one push per edge.
//  Pop: on SNDCS falling edge (end of read) head advances; pop on empty FIFO ignored.
//  Full: push with count==DEPTH and no same-cycle pop -> byte dropped, OVERRUN<=1 (reset only clears).
//  Simultaneous push+pop: pop then push; count unchanged; accepted even when full.
//  SNDDO: registered; head entry when non-empty, else last popped byte (held). Updates 1 cycle
//   after any push/pop; stable while SNDCS high (head not advanced until SNDCS falls).
//  PENDING = (count != 0), registered, same cycle as count.
//  NMI FSM:
//   IDLE  : PENDING -> PULSE (SNDNMI=1, cnt=0)
//   PULSE : after NMI_W cycles -> WAIT (SNDNMI=0)
//   WAIT  : on pop -> GAP (cnt=0); NMI not re-raised while head unread
//   GAP   : after NMI_GAP cycles -> PULSE if PENDING else IDLE
//   Pop during PULSE: SNDNMI stays to end of width, then FSM goes straight to GAP.
//  IRQ timer: counter 0..IRQ_PERIOD-1, free-running; VBLK rising edge forces counter to 0 and
//   fires IRQ. Each fire holds SNDIRQ=1 for IRQ_W cycles. Counter wrap fires too => 4 IRQs/frame.
//   VBLK edge during an active IRQ pulse restarts the IRQ_W count (no gap, no double pulse).
//  Widths: counters sized $clog2(param+1); count is $clog2(DEPTH)+1 bits; pointers wrap mod DEPTH.
// TESTING
//  T1 reset, SNDRQ pulse 8 cyc with CPUDO=8'h5A -> PENDING=1, SNDDO=5A, SNDNMI high exactly 64 cyc.
//  T2 SNDCS pulse after T1 -> PENDING=0 on falling edge+1, SNDDO holds 5A, NMI FSM GAP->IDLE, no NMI.
//  T3 push 01..05 no reads (DEPTH=4) -> 05 dropped, OVERRUN=1; reads return 01,02,03,04 in order,
//     NMI re-pulses after each pop with >=64 cyc low gap; OVERRUN stays 1.
//  T4 full FIFO, SNDRQ rise and SNDCS fall same cycle with CPUDO=AA -> count stays 4,
//     OVERRUN unchanged, AA read last.
//  T5 VBLK rise -> SNDIRQ high 256 cyc at t=0,200000,400000,600000; VBLK at t=150000 -> restart.
//  T6 RESET asserted mid NMI pulse with 2 queued -> next cycle SNDNMI=0, PENDING=0, SNDDO=00.

Source files
------------

// File: rtl/segasys1_sound_cmd_rx.sv
// Sound-side command receiver: latches main-CPU commands into a small FIFO,
// pulses NMI to the sound Z80 per unread command, and paces the sound IRQ.
module segasys1_sound_cmd_rx #(
    parameter int DEPTH      = 4,
    parameter int NMI_W      = 64,
    parameter int NMI_GAP    = 64,
    parameter int IRQ_PERIOD = 200000,
    parameter int IRQ_W      = 256
) (
    input  logic       CLK48M,
    input  logic       RESET,
    input  logic       SNDRQ,
    input  logic [7:0] CPUDO,
    input  logic       VBLK,
    input  logic       SNDCS,
    output logic [7:0] SNDDO,
    output logic       SNDNMI,
    output logic       SNDIRQ,
    output logic       PENDING,
    output logic       OVERRUN
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int NMI_MAX = (NMI_W > NMI_GAP) ? NMI_W : NMI_GAP;
    localparam int NMI_CW  = $clog2(NMI_MAX + 1);
    localparam int IRQ_CW  = $clog2(IRQ_PERIOD + 1);
    localparam int IW_CW   = $clog2(IRQ_W + 1);

    localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);
    localparam logic [NMI_CW-1:0] NMI_LAST = NMI_CW'(NMI_W - 1);
    localparam logic [NMI_CW-1:0] GAP_LAST = NMI_CW'(NMI_GAP - 1);
    localparam logic [IRQ_CW-1:0] IRQ_LAST = IRQ_CW'(IRQ_PERIOD - 1);
    localparam logic [IW_CW-1:0]  IW_LAST  = IW_CW'(IRQ_W - 1);

    typedef enum logic [1:0] {
        N_IDLE,
        N_PULSE,
        N_WAIT,
        N_GAP
    } nmi_st_t;

    logic             sndrq_q;
    logic             sndcs_q;
    logic             vblk_q;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             push_edge;
    logic             pop;
    logic             push_ok;
    logic [CNT_W-1:0] cnt_ap;
    logic [CNT_W-1:0] count_n;
    logic [PTR_W-1:0] head_n;
    logic [7:0]       head_data;

    assign push_edge = SNDRQ & ~sndrq_q;
    assign pop       = ~SNDCS & sndcs_q & (count != '0);
    assign push_ok   = push_edge & ((count != FULL) | pop);
    assign cnt_ap    = count - CNT_W'(pop);
    assign count_n   = cnt_ap + CNT_W'(push_ok);
    assign head_n    = head + PTR_W'(pop);
    // An empty queue after the pop means the incoming byte becomes the head.
    assign head_data = (cnt_ap == '0) ? CPUDO : mem[head_n];

    always_ff @(posedge CLK48M) begin
        if (push_ok) begin
            mem[tail] <= CPUDO;
        end
    end

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            sndrq_q <= 1'b0;
            sndcs_q <= 1'b0;
            vblk_q  <= 1'b0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            SNDDO   <= 8'h00;
            PENDING <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            sndrq_q <= SNDRQ;
            sndcs_q <= SNDCS;
            vblk_q  <= VBLK;
            head    <= head_n;
            count   <= count_n;
            PENDING <= (count_n != '0);
            if (push_ok) begin
                tail <= tail + PTR_W'(1);
            end
            if (push_edge && !push_ok) begin
                OVERRUN <= 1'b1;
            end
            if (count_n != '0) begin
                SNDDO <= head_data;
            end
        end
    end

    nmi_st_t           nmi_st;
    logic [NMI_CW-1:0] nmi_cnt;
    logic              popped;

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            nmi_st  <= N_IDLE;
            nmi_cnt <= '0;
            popped  <= 1'b0;
            SNDNMI  <= 1'b0;
        end else begin
            unique case (nmi_st)
                N_IDLE: begin
                    if (PENDING) begin
                        nmi_st  <= N_PULSE;
                        SNDNMI  <= 1'b1;
                        nmi_cnt <= '0;
                        popped  <= pop;
                    end
                end
                N_PULSE: begin
                    popped <= popped | pop;
                    if (nmi_cnt == NMI_LAST) begin
                        SNDNMI  <= 1'b0;
                        nmi_cnt <= '0;
                        nmi_st  <= (popped | pop) ? N_GAP : N_WAIT;
                    end else begin
                        nmi_cnt <= nmi_cnt + NMI_CW'(1);
                    end
                end
                N_WAIT: begin
                    if (pop) begin
                        nmi_st  <= N_GAP;
                        nmi_cnt <= '0;
                    end
                end
                N_GAP: begin
                    if (nmi_cnt == GAP_LAST) begin
                        nmi_cnt <= '0;
                        if (count_n != '0) begin
                            nmi_st <= N_PULSE;
                            SNDNMI <= 1'b1;
                            popped <= pop;
                        end else begin
                            nmi_st <= N_IDLE;
                        end
                    end else begin
                        nmi_cnt <= nmi_cnt + NMI_CW'(1);
                    end
                end
                default: nmi_st <= N_IDLE;
            endcase
        end
    end

    logic [IRQ_CW-1:0] irq_cnt;
    logic [IW_CW-1:0]  iw_cnt;
    logic              irq_fire;

    // VBLK re-phases the free-running timer so the four IRQs track the frame.
    assign irq_fire = (VBLK & ~vblk_q) | (irq_cnt == IRQ_LAST);

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            irq_cnt <= '0;
            iw_cnt  <= '0;
            SNDIRQ  <= 1'b0;
        end else begin
            irq_cnt <= irq_fire ? '0 : irq_cnt + IRQ_CW'(1);
            if (irq_fire) begin
                SNDIRQ <= 1'b1;
                iw_cnt <= '0;
            end else if (SNDIRQ) begin
                if (iw_cnt == IW_LAST) begin
                    SNDIRQ <= 1'b0;
                end else begin
                    iw_cnt <= iw_cnt + IW_CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_segasys1_sound_cmd_rx.sv
// Bench for segasys1_sound_cmd_rx: directed scenarios plus random traffic
// compared cycle by cycle against a queue/timestamp reference model.
module tb_segasys1_sound_cmd_rx;

    localparam int DEPTH      = 4;
    localparam int NMI_W      = 64;
    localparam int NMI_GAP    = 64;
    localparam int IRQ_PERIOD = 3000;
    localparam int IRQ_W      = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sndrq = 1'b0;
    logic [7:0] cpudo = 8'h00;
    logic       vblk = 1'b0;
    logic       sndcs = 1'b0;
    logic [7:0] snddo;
    logic       sndnmi;
    logic       sndirq;
    logic       pending;
    logic       overrun;

    always #5 clk = ~clk;

    segasys1_sound_cmd_rx #(
        .DEPTH(DEPTH), .NMI_W(NMI_W), .NMI_GAP(NMI_GAP),
        .IRQ_PERIOD(IRQ_PERIOD), .IRQ_W(IRQ_W)
    ) dut (
        .CLK48M(clk), .RESET(rst), .SNDRQ(sndrq), .CPUDO(cpudo),
        .VBLK(vblk), .SNDCS(sndcs), .SNDDO(snddo), .SNDNMI(sndnmi),
        .SNDIRQ(sndirq), .PENDING(pending), .OVERRUN(overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: byte queue for the FIFO, pulse start/read timestamps for NMI,
    // last-fire/last-zero timestamps for the IRQ timer.
    byte unsigned q[$];
    logic [7:0]   m_do = 8'h00;
    bit           m_ovr, m_nmi, m_irq;
    bit           p_rq, p_cs, p_vb;
    longint       t = 0;
    longint       s = -1, fp = -1, f = -1, z = 0;

    always @(posedge clk) begin
        bit     qb, pop, push, start;
        longint g0, ge;
        t++;
        if (rst) begin
            q.delete();
            m_do = 8'h00; m_ovr = 0;
            p_rq = 0; p_cs = 0; p_vb = 0;
            s = -1; fp = -1; f = -1; z = t;
        end else begin
            qb   = (q.size() != 0);
            pop  = p_cs && !sndcs && qb;
            push = sndrq && !p_rq;
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(cpudo);
                else m_ovr = 1;
            end
            if (q.size() != 0) m_do = q[0];
            if (s >= 0 && fp < 0 && pop) fp = t;
            start = 0;
            if (s < 0) begin
                start = qb;
            end else if (fp >= 0) begin
                g0 = (s + NMI_W > fp) ? s + NMI_W : fp;
                ge = g0 + NMI_GAP;
                if (t == ge) start = (q.size() != 0);
                else if (t > ge) start = qb;
            end
            if (start) begin
                s  = t;
                fp = pop ? t : -1;
            end
            if ((vblk && !p_vb) || t == z + IRQ_PERIOD) begin
                f = t;
                z = t;
            end
            p_rq = sndrq; p_cs = sndcs; p_vb = vblk;
        end
        m_nmi = (s >= 0) && (t < s + NMI_W);
        m_irq = (f >= 0) && (t < f + IRQ_W);
    end

    bit chk_on = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("SNDDO", snddo, m_do);
            check("PENDING", pending, q.size() != 0);
            check("OVERRUN", overrun, m_ovr);
            check("SNDNMI", sndnmi, m_nmi);
            check("SNDIRQ", sndirq, m_irq);
        end
    end

    int nmi_hi = 0;
    int irq_rises = 0;
    int irq_run = 0;
    int irq_last_run = 0;
    bit irq_prev = 0;

    always @(posedge clk) begin
        if (sndnmi) nmi_hi++;
        if (sndirq && !irq_prev) irq_rises++;
        if (sndirq) irq_run++;
        else if (irq_prev) begin
            irq_last_run = irq_run;
            irq_run = 0;
        end
        irq_prev = sndirq;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        cycles(2);
        rst = 0;
    endtask

    task automatic write_cmd(input logic [7:0] d, input int w);
        cpudo = d;
        sndrq = 1;
        cycles(w);
        sndrq = 0;
        cpudo = 8'($urandom);
        cycles(2);
    endtask

    task automatic read_cmd(output logic [7:0] d, input int w);
        sndcs = 1;
        cycles(1);
        d = snddo;
        cycles(w - 1);
        sndcs = 0;
        cycles(2);
    endtask

    task automatic wait_nmi(input int lim);
        int k = 0;
        while (!sndnmi && k < lim) begin
            cycles(1);
            k++;
        end
        check("nmi_wait", sndnmi, 1'b1);
    endtask

    task automatic wait_irq(input bit lvl, input int lim);
        int k = 0;
        while (sndirq != lvl && k < lim) begin
            cycles(1);
            k++;
        end
        check("irq_wait", sndirq, lvl);
    endtask

    task automatic pulse_vblk(input int w);
        vblk = 1;
        cycles(w);
        vblk = 0;
    endtask

    logic [7:0] rd;

    initial begin
        cycles(1);
        do_reset();
        chk_on = 1;
        check("rst_pending", pending, 1'b0);
        check("rst_snddo", snddo, 8'h00);

        // single command, NMI width
        nmi_hi = 0;
        write_cmd(8'h5A, 8);
        cycles(100);
        check("t1_nmi_width", nmi_hi, NMI_W);
        check("t1_snddo", snddo, 8'h5A);
        check("t1_pending", pending, 1'b1);

        // read it back, no further NMI
        read_cmd(rd, 4);
        check("t2_read", rd, 8'h5A);
        check("t2_pending", pending, 1'b0);
        check("t2_hold", snddo, 8'h5A);
        nmi_hi = 0;
        cycles(150);
        check("t2_no_nmi", nmi_hi, 0);

        // overflow by one, then drain in order
        for (int i = 1; i <= 5; i++) write_cmd(8'(i), 4);
        check("t3_overrun", overrun, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            wait_nmi(400);
            read_cmd(rd, 3);
            check("t3_order", rd, 8'(i));
        end
        cycles(200);
        check("t3_ovr_sticky", overrun, 1'b1);
        check("t3_empty", pending, 1'b0);

        // push and pop in the same cycle on a full queue
        do_reset();
        for (int i = 1; i <= 4; i++) write_cmd(8'(i * 16), 3);
        sndcs = 1;
        cycles(3);
        check("t4_head", snddo, 8'h10);
        sndcs = 0;
        sndrq = 1;
        cpudo = 8'hAA;
        cycles(5);
        sndrq = 0;
        cycles(2);
        check("t4_ovr", overrun, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            read_cmd(rd, 2);
            check("t4_order", rd, (i == 5) ? 8'hAA : 8'(i * 16));
        end
        check("t4_empty", pending, 1'b0);

        // IRQ cadence and VBLK restart during an active pulse
        do_reset();
        irq_rises = 0;
        pulse_vblk(10);
        cycles(3 * IRQ_PERIOD + 300);
        check("t5_rises", irq_rises, 4);
        wait_irq(1'b1, IRQ_PERIOD + 500);
        cycles(100);
        pulse_vblk(5);
        wait_irq(1'b0, 2 * IRQ_W);
        cycles(2);
        check("t5_restart_len", irq_last_run, 101 + IRQ_W);
        cycles(IRQ_PERIOD / 4);
        pulse_vblk(3);
        cycles(IRQ_PERIOD + 400);

        // reset in the middle of an NMI pulse
        write_cmd(8'h33, 3);
        write_cmd(8'h44, 3);
        wait_nmi(400);
        cycles(5);
        rst = 1;
        cycles(1);
        check("t6_nmi", sndnmi, 1'b0);
        check("t6_pending", pending, 1'b0);
        check("t6_snddo", snddo, 8'h00);
        cycles(1);
        rst = 0;

        // random traffic against the model
        for (int it = 0; it < 400; it++) begin
            int op;
            op = int'($urandom_range(0, 19));
            if (op < 7) begin
                write_cmd(8'($urandom), int'($urandom_range(2, 10)));
            end else if (op < 12) begin
                read_cmd(rd, int'($urandom_range(1, 6)));
            end else if (op < 15) begin
                cycles(int'($urandom_range(1, 150)));
            end else if (op < 17) begin
                pulse_vblk(int'($urandom_range(1, 20)));
            end else if (op < 19) begin
                sndcs = 1;
                cycles(int'($urandom_range(1, 4)));
                sndcs = 0;
                sndrq = 1;
                cpudo = 8'($urandom);
                cycles(3);
                sndrq = 0;
                cycles(2);
            end else begin
                do_reset();
            end
        end
        cycles(300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
